grid_loader: RTL and testbench

GRID_LOADER -- requirements
Module: grid_loader

---
 rtl/grid_loader.sv | 128 ++++++++++++
 tb/tb_grid_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/grid_loader.sv
// Loads an 8x8 cell pattern one row byte at a time into a shadow register and
// publishes it on grid in a single step once all eight rows have arrived.
module grid_loader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [63:0] grid,
  output logic        load,
  output logic        busy,
  output logic [2:0]  row_idx,
  output logic        err
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned GRID_W = 64;
  localparam int unsigned ROW_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GRID_W-1:0]   shadow_q, shadow_d;
  logic [GRID_W-1:0]   grid_q, grid_d;
  logic                err_q, err_d;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      grid_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      grid_q   <= grid_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic; start outranks both a pending byte and timeout expiry
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    grid_d   = grid_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RECV;
          row_d    = '0;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      S_RECV: begin
        if (start) begin
          row_d    = '0;
          cnt_d    = '0;
          shadow_d = '0;
        end else if (byte_valid) begin
          // Row r lands at bits [63-8r -: 8]; 7-r equals ~r for a 3-bit index
          shadow_d[{~row_q, 3'b000} +: 8] = byte_data;
          row_d = row_q + 3'd1;
          cnt_d = '0;
          if (row_q == 3'd7) begin
            state_d = S_DONE;
            grid_d  = shadow_d;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d  = S_IDLE;
          err_d    = 1'b1;
          row_d    = '0;
          cnt_d    = '0;
          shadow_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State-decoded handshake and status outputs
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    case (state_q)
      S_RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        load = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign grid    = grid_q;
  assign row_idx = row_q;
  assign err     = err_q;

endmodule

// File: tb/tb_grid_loader.sv
// Randomized and directed bench for grid_loader against a queue-based
// reference of the row-loading protocol.
module tb_grid_loader;

  localparam int unsigned TO = 5;

  logic        clk;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [63:0] grid;
  logic        load;
  logic        busy;
  logic [2:0]  row_idx;
  logic        err;

  grid_loader #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .grid       (grid),
    .load       (load),
    .busy       (busy),
    .row_idx    (row_idx),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: phase 0 = idle, 1 = receiving, 2 = publishing
  int          m_phase;
  logic [7:0]  m_rows[$];
  int          m_gap;
  logic [63:0] m_grid;
  logic        m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] pack_rows();
    logic [63:0] g = '0;
    foreach (m_rows[i]) g = {g[55:0], m_rows[i]};
    return g;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_rows.delete();
    m_gap  = 0;
    m_grid = '0;
    m_err  = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic v, input logic [7:0] d);
    m_err = 1'b0;
    case (m_phase)
      0: if (s) begin
        m_phase = 1;
        m_rows.delete();
        m_gap = 0;
      end
      1: begin
        if (s) begin
          m_rows.delete();
          m_gap = 0;
        end else if (v) begin
          m_rows.push_back(d);
          m_gap = 0;
          if (m_rows.size() == 8) begin
            m_grid  = pack_rows();
            m_phase = 2;
            m_rows.delete();
          end
        end else begin
          m_gap++;
          if (m_gap == TO) begin
            m_phase = 0;
            m_err   = 1'b1;
            m_rows.delete();
            m_gap = 0;
          end
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    check("byte_ready", 64'(byte_ready), 64'(m_phase == 1));
    check("busy",       64'(busy),       64'(m_phase != 0));
    check("load",       64'(load),       64'(m_phase == 2));
    check("err",        64'(err),        64'(m_err));
    check("grid",       grid,            m_grid);
    if (m_phase == 1) check("row_idx", 64'(row_idx), 64'(m_rows.size()));
  endtask

  // One clock: check current outputs, then drive inputs for the next edge
  task automatic cycle(input logic s, input logic v, input logic [7:0] d);
    @(negedge clk);
    check_outputs();
    start      = s;
    byte_valid = v;
    byte_data  = d;
    model_step(s, v, d);
  endtask

  logic [7:0] pat [8];

  initial begin
    pat[0] = 8'h80; pat[1] = 8'h01; pat[2] = 8'hFF; pat[3] = 8'h00;
    pat[4] = 8'h3C; pat[5] = 8'hC3; pat[6] = 8'hAA; pat[7] = 8'h55;
    reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = '0;
    model_reset();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Bytes offered while idle must be ignored
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hA5);

    // Full back-to-back load; start during the publish cycle is ignored
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, pat[i]);
    cycle(1'b1, 1'b0, 8'h00);
    check("full_load", 64'(load), 64'd1);
    check("full_grid", grid, 64'h8001FF003CC3AA55);
    cycle(1'b0, 1'b0, 8'h00);

    // Throttled load with three idle cycles between bytes
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, pat[i]);
      if (i != 7) for (int g = 0; g < 3; g++) cycle(1'b0, 1'b0, 8'h00);
    end
    cycle(1'b0, 1'b0, 8'h00);
    check("thr_grid", grid, 64'h8001FF003CC3AA55);

    // Timeout after three bytes leaves grid untouched
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h11);
    for (int i = 0; i < int'(TO); i++) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    check("to_err", 64'(err), 64'd1);
    check("to_grid", grid, 64'h8001FF003CC3AA55);

    // Restart after five bytes, then all-ones pattern
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h12);
    cycle(1'b1, 1'b1, 8'h34);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'hFF);
    cycle(1'b0, 1'b0, 8'h00);
    check("rst_grid", grid, 64'hFFFFFFFFFFFFFFFF);

    // Start coincides with timeout expiry: restart wins, no err
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < int'(TO) - 1; i++) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    check("start_wins_err", 64'(err), 64'd0);
    check("start_wins_busy", 64'(busy), 64'd1);

    // Asynchronous reset while receiving row 4
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h77);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_grid",  grid, 64'h0);
    check("arst_busy",  64'(busy), 64'd0);
    check("arst_ready", 64'(byte_ready), 64'd0);
    check("arst_row",   64'(row_idx), 64'd0);
    model_reset();
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b0;
    check_outputs();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'h5A);

    // Randomized traffic with varying byte density
    begin
      int dens = 70;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 49) == 0) dens = int'($urandom_range(10, 100));
        cycle(($urandom_range(0, 39) == 0),
              (int'($urandom_range(0, 99)) < dens),
              8'($urandom));
      end
    end
    cycle(1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
